// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an external 8:1 (2**SEL_W:1) mux: steps sel through every channel,
// samples y on the last dwell cycle of each, and presents the assembled word with a done pulse.
module mux_scan_ctrl #(
    parameter int SEL_W = 3,
    parameter int DWELL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cont,
    input  logic                  y,
    output logic [SEL_W-1:0]      sel,
    output logic                  busy,
    output logic                  done,
    output logic [(2**SEL_W)-1:0] data_out
);

    localparam int N_CH  = 2 ** SEL_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  dwell_q, dwell_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [N_CH-1:0]   data_q, data_d;
    logic [N_CH-1:0]   shadow_q, shadow_d;

    logic sample_edge;
    logic last_ch;

    assign sample_edge = (state_q == SCAN) && (dwell_q == CNT_W'(DWELL - 1));
    assign last_ch     = (sel_q == SEL_W'(N_CH - 1));

    // State register: every flop, synchronous reset with priority over all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            dwell_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= '0;
            shadow_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop sees the pre-edge value of its neighbours.
            state_q  <= state_d;
            sel_q    <= sel_d;
            dwell_q  <= dwell_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            data_q   <= data_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (sample_edge && last_ch && !cont) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d    = sel_q;
        dwell_d  = dwell_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        data_d   = data_q;
        shadow_d = shadow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d    = '0;
                    dwell_d  = '0;
                    busy_d   = 1'b1;
                    shadow_d = '0;
                end
            end
            SCAN: begin
                if (!sample_edge) begin
                    dwell_d = dwell_q + CNT_W'(1);
                end else begin
                    shadow_d[sel_q] = y;
                    dwell_d         = '0;
                    if (!last_ch) begin
                        sel_d = sel_q + SEL_W'(1);
                    end else begin
                        // Final channel goes straight into the word; shadow holds the rest.
                        data_d = {y, shadow_q[N_CH-2:0]};
                        done_d = 1'b1;
                        sel_d  = '0;
                        if (cont) shadow_d = '0;
                        else      busy_d   = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    assign sel      = sel_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: directed vector table, hand-written corner
// sequences and a randomized run, against DWELL=1 and DWELL=3 instances.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic [7:0] mux_in = 8'h75;

    logic [2:0] sel0, sel3;
    logic       busy0, busy3, done0, done3, y0, y3;
    logic [7:0] data0, data3;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // The combinational mux sitting in front of each sequencer.
    assign y0 = mux_in[sel0];
    assign y3 = mux_in[sel3];

    mux_scan_ctrl #(.SEL_W(3), .DWELL(1)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .y(y0),
        .sel(sel0), .busy(busy0), .done(done0), .data_out(data0)
    );

    mux_scan_ctrl #(.SEL_W(3), .DWELL(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .y(y3),
        .sel(sel3), .busy(busy3), .done(done3), .data_out(data3)
    );

    // Reference model: a scan is "elapsed edges since it started"; channel k is
    // sampled when elapsed reaches (k+1)*dwell.
    bit         m_active[2];
    int         m_elapsed[2];
    logic [7:0] m_word[2];
    logic [7:0] m_data[2];
    bit         m_done[2];
    int         m_dwell[2] = '{1, 3};
    bit         model_dut0 = 1'b0;

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_active[m] = 0; m_elapsed[m] = 0;
                m_word[m] = '0; m_data[m] = '0; m_done[m] = 0;
            end else begin
                m_done[m] = 0;
                if (m_active[m]) begin
                    m_elapsed[m]++;
                    if (m_elapsed[m] % m_dwell[m] == 0) begin
                        int ch;
                        ch = m_elapsed[m] / m_dwell[m] - 1;
                        m_word[m][ch] = mux_in[ch];
                        if (ch == 7) begin
                            m_data[m] = m_word[m];
                            m_done[m] = 1;
                            if (cont) begin
                                m_elapsed[m] = 0; m_word[m] = '0;
                            end else begin
                                m_active[m] = 0;
                            end
                        end
                    end
                end else if (start) begin
                    m_active[m] = 1; m_elapsed[m] = 0; m_word[m] = '0;
                end
            end
        end
    endtask

    function automatic int exp_sel(int m);
        return m_active[m] ? m_elapsed[m] / m_dwell[m] : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (model_dut0) begin
            check("d1.sel",  32'(sel0),  32'(exp_sel(0)));
            check("d1.busy", 32'(busy0), 32'(m_active[0]));
            check("d1.done", 32'(done0), 32'(m_done[0]));
            check("d1.data", 32'(data0), 32'(m_data[0]));
        end
        check("d3.sel",  32'(sel3),  32'(exp_sel(1)));
        check("d3.busy", 32'(busy3), 32'(m_active[1]));
        check("d3.done", 32'(done3), 32'(m_done[1]));
        check("d3.data", 32'(data3), 32'(m_data[1]));
    endtask

    typedef struct {
        logic       rst, start, cont;
        logic [7:0] mux_in;
        logic [2:0] sel;
        logic       busy, done;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int ndone, lat, nw;
        int done_at[2];
        logic [7:0] words[2];
        logic [7:0] old_in, new_in;

        // Reset, one start pulse, eight channel steps, then the done cycle and idle.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h75, 3'd0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h75, 3'd0, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h75, 3'd0, 1'b1, 1'b0, 8'h00};
        for (int i = 3; i <= 9; i++)
            vecs[i] = '{1'b0, 1'b0, 1'b0, 8'h75, 3'(i - 2), 1'b1, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h75, 3'd0, 1'b0, 1'b1, 8'h75};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h75, 3'd0, 1'b0, 1'b0, 8'h75};

        for (int i = 0; i < 12; i++) begin
            rst = vecs[i].rst; start = vecs[i].start;
            cont = vecs[i].cont; mux_in = vecs[i].mux_in;
            tick();
            check($sformatf("vec%0d.sel", i),  32'(sel0),  32'(vecs[i].sel));
            check($sformatf("vec%0d.busy", i), 32'(busy0), 32'(vecs[i].busy));
            check($sformatf("vec%0d.done", i), 32'(done0), 32'(vecs[i].done));
            check($sformatf("vec%0d.data", i), 32'(data0), 32'(vecs[i].data));
        end
        model_dut0 = 1'b1;

        // DWELL=3: done 24 edges after the start edge.
        repeat (20) tick();
        start = 1'b1; tick(); start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done3 === 1'b1) begin lat = i; break; end
        end
        check("dwell3.latency", 32'(lat), 32'd24);
        check("dwell3.data", 32'(data3), 32'h75);

        // Second start while busy is ignored.
        repeat (4) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        check("restart.sel_before", 32'(sel0), 32'd3);
        start = 1'b1; tick(); start = 1'b0;
        check("restart.sel_after", 32'(sel0), 32'd4);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done0 === 1'b1) ndone++;
        end
        check("restart.done_count", 32'(ndone), 32'd1);
        check("restart.data", 32'(data0), 32'h75);

        // Continuous scan with the mux input changing while sel=5.
        repeat (30) tick();
        old_in = 8'h75; new_in = 8'hA5;
        mux_in = old_in; cont = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        check("cont.sel5", 32'(sel0), 32'd5);
        mux_in = new_in;
        nw = 0;
        for (int i = 0; i < 40 && nw < 2; i++) begin
            tick();
            if (done0 === 1'b1) begin done_at[nw] = i; words[nw] = data0; nw++; end
        end
        check("cont.words_seen", 32'(nw), 32'd2);
        if (nw == 2) begin
            check("cont.word0", 32'(words[0]), 32'({new_in[7:5], old_in[4:0]}));
            check("cont.word1", 32'(words[1]), 32'(new_in));
            check("cont.spacing", 32'(done_at[1] - done_at[0]), 32'd8);
        end
        check("cont.busy", 32'(busy0), 32'd1);
        cont = 1'b0;
        repeat (30) tick();

        // Reset in the middle of a scan aborts it without a done pulse.
        mux_in = 8'h75;
        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        check("abort.sel4", 32'(sel0), 32'd4);
        rst = 1'b1; tick(); rst = 1'b0;
        check("abort.sel", 32'(sel0), 32'd0);
        check("abort.busy", 32'(busy0), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done0 === 1'b1) ndone++;
        end
        check("abort.done_count", 32'(ndone), 32'd0);
        check("abort.data", 32'(data0), 32'h00);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(63) == 0);
            start = ($urandom_range(5) == 0);
            cont  = ($urandom_range(3) == 0);
            if ($urandom_range(3) == 0) mux_in = 8'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
